mem_port_arbiter: RTL and testbench

- Shares one single-ported memory/LSU bus between two pipeline requesters: instruction fetch (IF) and load/store (LS, MEM stage).
- Data-priority arbitration with a starvation guard for fetch. At most one outstanding transaction.
- A response timeout keeps a hung memory from deadlocking the pipeline.
- Sits between the IF/MEM stages and the memory subsystem. Hazard/stall logic consumes gnt/rvalid as stall conditions.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store.
// Load/store has priority, a starvation guard protects fetch, and a response timeout prevents deadlock.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_be_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic          grant_ls, grant_if;
    logic          tmo_hit;
    logic          rsp_ok, rsp_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
            tmo_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            tmo_q    <= (state_q == IDLE) ? '0 : tmo_q + TW'(1);
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    // owner_q: 1 = load/store owns the transaction, 0 = fetch
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        grant_ls    = 1'b0;
        grant_if    = 1'b0;
        rsp_ok      = 1'b0;
        rsp_err     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES));

        case (state_q)
            IDLE: begin
                if (ls_req_i && (starve_q < SW'(STARVE_LIMIT))) begin
                    grant_ls = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end else if (ls_req_i) begin
                    grant_ls = 1'b1;
                end

                if (grant_ls && if_req_i) begin
                    starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end

                if (grant_ls) begin
                    owner_d = 1'b1;
                    we_d    = ls_we_i;
                    addr_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    be_d    = ls_be_i;
                    state_d = REQ;
                end else if (grant_if) begin
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    be_d    = 4'hF;
                    state_d = REQ;
                end
            end
            REQ: begin
                // The request is withdrawn in the terminal cycle so a late grant cannot start a transfer
                mem_req_o   = !tmo_hit;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_be_o    = be_q;
                if (tmo_hit) begin
                    rsp_err = 1'b1;
                    state_d = IDLE;
                end else if (mem_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    rsp_ok  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    rsp_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if_gnt_o    = grant_if && !rst_i;
        ls_gnt_o    = grant_ls && !rst_i;
        if_rvalid_o = (rsp_ok || rsp_err) && !owner_q;
        ls_rvalid_o = (rsp_ok || rsp_err) && owner_q;
        if_rdata_o  = (rsp_ok && !owner_q) ? mem_rdata_i : '0;
        ls_rdata_o  = (rsp_ok && owner_q) ? mem_rdata_i : '0;
        if_err_o    = rsp_err && !owner_q;
        ls_err_o    = rsp_err && owner_q;
        busy_o      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory model plus per-port response scoreboards.
module tb_mem_port_arbiter;

    localparam int TMO = 8;
    localparam int SL  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
    logic [3:0]  ls_be_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        busy_o;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_if[$];
    rsp_t exp_ls[$];
    bit   gnt_log[$];
    rsp_t mon_e;

    int n_cmp  = 0;
    int n_fail = 0;

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    bit          mem_dead  = 1'b0;
    int          m_req_wait = 0;
    int          m_rsp_wait = 0;
    bit          m_pending  = 1'b0;
    logic [31:0] m_data     = '0;

    task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a, input logic we,
                                             input logic [31:0] wd, input logic [3:0] be);
        return (a * 32'h9E37_79B9) ^ wd ^ {be, 27'd0, we};
    endfunction

    function automatic logic [15:0] pack_log();
        logic [7:0] bits = '0;
        foreach (gnt_log[i]) bits = {bits[6:0], gnt_log[i]};
        return {8'(gnt_log.size()), bits};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_gnt(input bit is_ls);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            seen = is_ls ? ls_gnt_o : if_gnt_o;
        end
        checkOutput(is_ls ? "ls_gnt_seen" : "if_gnt_seen", 160'(seen), 160'(1));
        if (seen) checkOutput("gnt_from_idle", 160'(busy_o), 160'(0));
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk_i);
            idle = !busy_o;
        end
        checkOutput("reach_idle", 160'(idle), 160'(1));
    endtask

    // Issue one request, record its expected response, hold until granted
    task automatic applyStimulus(input bit is_ls, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input bit exp_err);
        rsp_t e;
        e.err = exp_err;
        if (is_ls) begin
            ls_req_i = 1'b1; ls_we_i = we; ls_addr_i = addr; ls_wdata_i = wdata; ls_be_i = be;
            e.data = exp_err ? 32'h0 : mem_data(addr, we, wdata, be);
            exp_ls.push_back(e);
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
            e.data = exp_err ? 32'h0 : mem_data(addr, 1'b0, 32'h0, 4'hF);
            exp_if.push_back(e);
        end
        wait_gnt(is_ls);
        tick();
        if (is_ls) ls_req_i = 1'b0;
        else if_req_i = 1'b0;
    endtask

    // Memory model: grant after gnt_delay REQ cycles, respond rsp_delay cycles after the first RSP cycle
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            tick();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            if (rst_i) begin
                m_pending = 1'b0; m_req_wait = 0;
            end else if (m_pending) begin
                if (m_rsp_wait >= rsp_delay) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = m_data; m_pending = 1'b0;
                end else begin
                    m_rsp_wait++;
                end
            end else if (mem_req_o && !mem_dead) begin
                if (m_req_wait >= gnt_delay) begin
                    mem_gnt_i = 1'b1; m_pending = 1'b1; m_rsp_wait = 0; m_req_wait = 0;
                    m_data = mem_data(mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o);
                end else begin
                    m_req_wait++;
                end
            end else begin
                m_req_wait = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (if_gnt_o) gnt_log.push_back(1'b0);
                if (ls_gnt_o) gnt_log.push_back(1'b1);
                checkOutput("single_gnt", 160'(if_gnt_o & ls_gnt_o), 160'(0));
                if (if_rvalid_o) begin
                    if (exp_if.size() == 0) begin
                        checkOutput("if_unexpected_rvalid", 160'(if_rvalid_o), 160'(0));
                    end else begin
                        mon_e = exp_if.pop_front();
                        checkOutput("if_rsp", {if_rdata_o, if_err_o}, {mon_e.data, mon_e.err});
                    end
                end else begin
                    checkOutput("if_quiet", {if_rdata_o, if_err_o}, 160'(0));
                end
                if (ls_rvalid_o) begin
                    if (exp_ls.size() == 0) begin
                        checkOutput("ls_unexpected_rvalid", 160'(ls_rvalid_o), 160'(0));
                    end else begin
                        mon_e = exp_ls.pop_front();
                        checkOutput("ls_rsp", {ls_rdata_o, ls_err_o}, {mon_e.data, mon_e.err});
                    end
                end else begin
                    checkOutput("ls_quiet", {ls_rdata_o, ls_err_o}, 160'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
        #1;
        checkOutput("reset_outputs",
            {if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, busy_o}, 160'(0));
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // Single fetch with minimum latency
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        checkOutput("fetch_req_cycle", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, busy_o},
                    {1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1});
        @(negedge clk_i);
        checkOutput("fetch_rsp_cycle", {if_rvalid_o, mem_req_o, busy_o}, {1'b1, 1'b0, 1'b1});
        @(negedge clk_i);
        checkOutput("fetch_done_idle", 160'(busy_o), 160'(0));
        tick();

        // Simultaneous store and fetch
        gnt_log.delete();
        fork
            begin
                applyStimulus(1'b1, 1'b1, 32'h20, 32'h55, 4'b0011, 1'b0);
                @(negedge clk_i);
                checkOutput("store_mem_fields", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                            {1'b1, 1'b1, 32'h20, 32'h55, 4'b0011});
            end
            applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        join
        wait_idle();
        checkOutput("order_ls_then_if", 160'(pack_log()), 160'({8'd2, 8'b10}));

        // Both requesters held continuously
        gnt_log.delete();
        tick();
        fork
            for (int k = 0; k < 4; k++)
                applyStimulus(1'b1, k[0], 32'h1000 + 32'(k * 4), 32'hA000 + 32'(k), 4'(k + 1), 1'b0);
            for (int k = 0; k < 2; k++)
                applyStimulus(1'b0, 1'b0, 32'h2000 + 32'(k * 4), 32'h0, 4'h0, 1'b0);
        join
        wait_idle();
        checkOutput("order_starve_guard", 160'(pack_log()), 160'({8'd6, 8'b00110110}));

        // Memory never grants: timeout error completion
        tick();
        mem_dead = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk_i);
            checkOutput($sformatf("tmo_wait_%0d", k), {mem_req_o, ls_rvalid_o}, 160'(2'b10));
        end
        @(negedge clk_i);
        checkOutput("tmo_fire", {ls_rvalid_o, ls_err_o, mem_req_o}, 160'(3'b110));
        @(negedge clk_i);
        checkOutput("tmo_after", {busy_o, mem_req_o}, 160'(0));
        mem_dead = 1'b0;
        tick();

        // Response coinciding with the terminal count completes normally
        rsp_delay = 7;
        applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk_i);
            checkOutput($sformatf("coincide_wait_%0d", k), 160'(if_rvalid_o), 160'(0));
        end
        @(negedge clk_i);
        checkOutput("coincide_rsp", {if_rvalid_o, if_err_o}, 160'(2'b10));
        @(negedge clk_i);
        checkOutput("coincide_idle", 160'(busy_o), 160'(0));
        tick();

        // Response one cycle too late: error completion, late rvalid dropped
        rsp_delay = 8;
        applyStimulus(1'b0, 1'b0, 32'h340, 32'h0, 4'h0, 1'b1);
        repeat (TMO) @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("late_tmo", {if_rvalid_o, if_err_o}, 160'(2'b11));
        @(negedge clk_i);
        checkOutput("late_dropped", {mem_rvalid_i, if_rvalid_o, busy_o}, 160'(3'b100));
        tick(); tick();

        // Reset in the middle of a response wait
        rsp_delay = 5;
        applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("pre_reset_busy", 160'(busy_o), 160'(1));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("reset_async",
            {if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, busy_o}, 160'(0));
        exp_if.delete();
        tick(); tick();
        rst_i = 1'b0;
        rsp_delay = 0;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
        wait_idle();
        tick(); tick();

        checkOutput("if_queue_drained", 160'(exp_if.size()), 160'(0));
        checkOutput("ls_queue_drained", 160'(exp_ls.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
